// File: rtl/instruction_decoder_pkg.sv
// Shared widths, decoded-field bundle, opcode names and skid-buffer states for the
// pipelined instruction decoder.
package instruction_decoder_pkg;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_OPC_W   = 5;
  localparam int DEF_REG_W   = 3;
  localparam int DEF_IMM_W   = 8;
  localparam int DEF_DATA_W  = 16;

  localparam logic [DEF_OPC_W-1:0] OPC_NOP = 5'h00;
  localparam logic [DEF_OPC_W-1:0] OPC_MOV = 5'h08;
  localparam logic [DEF_OPC_W-1:0] OPC_LDI = 5'h0C;

  // Field bundle at the default widths; member order matches the top-level payload packing.
  typedef struct packed {
    logic [DEF_OPC_W-1:0]  opcode;
    logic [DEF_REG_W-1:0]  rd;
    logic [DEF_REG_W-1:0]  rs;
    logic [DEF_IMM_W-1:0]  k;
    logic [DEF_DATA_W-1:0] k_sext;
    logic                  illegal;
  } decoded_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/decoder_skid_buf.sv
// Generic two-entry valid/ready skid buffer; main drives the outputs, skid absorbs the
// word that arrives in the cycle downstream stalls.
module decoder_skid_buf
  import instruction_decoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state;
  skid_state_t  state_nxt;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_acc;
  logic         out_acc;
  logic         load_main;
  logic         load_skid;
  logic         main_from_skid;

  // Handshakes are derived from the state register alone so in_ready never sees out_ready.
  assign in_acc  = in_valid && (state != SKID_FULL);
  assign out_acc = out_ready && (state != SKID_EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SKID_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SKID_EMPTY: if (in_acc) state_nxt = SKID_ONE;
      SKID_ONE: begin
        if (in_acc && !out_acc)      state_nxt = SKID_FULL;
        else if (!in_acc && out_acc) state_nxt = SKID_EMPTY;
      end
      SKID_FULL:  if (out_acc) state_nxt = SKID_ONE;
      default:    state_nxt = SKID_EMPTY;
    endcase
  end

  always_comb begin
    in_ready       = (state != SKID_FULL);
    out_valid      = (state != SKID_EMPTY);
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      SKID_EMPTY: load_main = in_acc;
      SKID_ONE: begin
        load_main = in_acc && out_acc;
        load_skid = in_acc && !out_acc;
      end
      SKID_FULL:  main_from_skid = out_acc;
      default:    load_main = 1'b0;
    endcase
  end

  // Main only changes on a load, so a stalled word stays put on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)           main_q <= in_data;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  assign out_data = main_q;

endmodule

// File: rtl/instruction_decoder_pipe.sv
// Pipelined instruction decoder: field split, sign-extended immediate and illegal flag
// behind a 2-entry skid buffer. Define DEC_PERF_CNT_EN to add transfer counters.
module instruction_decoder_pipe
  import instruction_decoder_pkg::*;
#(
  parameter int                    INSTR_W    = DEF_INSTR_W,
  parameter int                    OPC_W      = DEF_OPC_W,
  parameter int                    REG_W      = DEF_REG_W,
  parameter int                    IMM_W      = DEF_IMM_W,
  parameter int                    DATA_W     = DEF_DATA_W,
  parameter logic [2**OPC_W-1:0]   LEGAL_MASK = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs,
  output logic [IMM_W-1:0]   k,
  output logic [DATA_W-1:0]  k_sext,
  output logic               illegal
`ifdef DEC_PERF_CNT_EN
  ,
  output logic [31:0]        decoded_cnt,
  output logic [31:0]        illegal_cnt
`endif
);

  localparam int PAY_W = OPC_W + 2*REG_W + IMM_W + DATA_W + 1;

  if (OPC_W + REG_W + IMM_W != INSTR_W) begin : g_chk_fields
    $fatal(1, "instruction_decoder_pipe: OPC_W + REG_W + IMM_W must equal INSTR_W");
  end
  if (OPC_W + 2*REG_W > INSTR_W) begin : g_chk_regs
    $fatal(1, "instruction_decoder_pipe: OPC_W + 2*REG_W must not exceed INSTR_W");
  end
  if (DATA_W < IMM_W) begin : g_chk_data
    $fatal(1, "instruction_decoder_pipe: DATA_W must be at least IMM_W");
  end

  logic [OPC_W-1:0]  dec_opcode;
  logic [REG_W-1:0]  dec_rd;
  logic [REG_W-1:0]  dec_rs;
  logic [IMM_W-1:0]  dec_k;
  logic [DATA_W-1:0] dec_k_sext;
  logic              dec_illegal;
  logic [PAY_W-1:0]  in_payload;
  logic [PAY_W-1:0]  out_payload;

  // Decode at capture so the buffer holds finished fields rather than raw words.
  assign dec_opcode  = instruction[INSTR_W-1 -: OPC_W];
  assign dec_rd      = instruction[INSTR_W-OPC_W-1 -: REG_W];
  assign dec_rs      = instruction[INSTR_W-OPC_W-REG_W-1 -: REG_W];
  assign dec_k       = instruction[IMM_W-1:0];
  assign dec_k_sext  = DATA_W'($signed(dec_k));
  assign dec_illegal = ~LEGAL_MASK[dec_opcode];
  assign in_payload  = {dec_opcode, dec_rd, dec_rs, dec_k, dec_k_sext, dec_illegal};

  decoder_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {opcode, rd, rs, k, k_sext, illegal} = out_payload;

`ifdef DEC_PERF_CNT_EN
  // Both counters advance on output transfers and wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decoded_cnt <= '0;
      illegal_cnt <= '0;
    end else if (out_valid && out_ready) begin
      decoded_cnt <= decoded_cnt + 32'd1;
      if (illegal) illegal_cnt <= illegal_cnt + 32'd1;
    end
  end
`endif

endmodule
